calc_bin2bcd: RTL and testbench



---
 rtl/calc_bin2bcd_if.sv | 22 ++
 rtl/calc_bin2bcd.sv | 123 ++++++++++++
 tb/tb_calc_bin2bcd.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/calc_bin2bcd_if.sv
// Handshake bundle between the calculator adder stage and the BCD display feed.
// Carries the optional leading-zero blank vector when CALC_BCD_BLANK_EN is defined.
interface calc_bin2bcd_if #(
  parameter int N      = 4,
  parameter int DIGITS = 2
);
  logic                  start;
  logic [N-1:0]          sum;
  logic                  cout;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
`ifdef CALC_BCD_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (output start, sum, cout, input bcd, busy, done, blank);
  modport slave  (input start, sum, cout, output bcd, busy, done, blank);
`else
  modport master (output start, sum, cout, input bcd, busy, done);
  modport slave  (input start, sum, cout, output bcd, busy, done);
`endif
endinterface

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble converter: {cout,sum} -> packed BCD, one bit per clock.
// Optional macro CALC_BCD_BLANK_EN adds a leading-zero blank vector on the bus.
module calc_bin2bcd #(
  parameter int N      = 4,
  parameter int DIGITS = 2
) (
  input logic           clk,
  input logic           rst,
  calc_bin2bcd_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_reg, state_next;
  logic [N:0]      bin_reg;
  logic [BW-1:0]   work_reg;
  logic [BW-1:0]   bcd_reg;
  logic [CW-1:0]   count_reg;
  logic            done_reg;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   work_next;
  logic [N:0]      bin_next;
  logic            last_shift;

  // Add-3 correction on every working digit before the shift
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5) ?
                              work_reg[4*gi +: 4] + 4'd3 : work_reg[4*gi +: 4];
    end
  endgenerate

  assign work_next  = {adj[BW-2:0], bin_reg[N]};
  assign bin_next   = {bin_reg[N-1:0], 1'b0};
  assign last_shift = (count_reg == LAST);

`ifdef CALC_BCD_BLANK_EN
  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS-1:0] blank_next;
  logic [DIGITS-1:0] blank_reg;

  // A digit is blanked only when it and every digit above it are zero
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
      assign digit_zero[gi] = (work_next[4*gi +: 4] == 4'd0);
    end
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign blank_next[gi] = &digit_zero[DIGITS-1:gi];
    end
  endgenerate
  assign blank_next[0] = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_reg <= '0;
    end else if (state_reg == SHIFT && last_shift) begin
      blank_reg <= blank_next;
    end
  end

  always_comb begin
    bus.blank = blank_reg;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_reg   <= '0;
      work_reg  <= '0;
      bcd_reg   <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            bin_reg   <= {bus.cout, bus.sum};
            work_reg  <= '0;
            count_reg <= '0;
          end
        end
        SHIFT: begin
          work_reg  <= work_next;
          bin_reg   <= bin_next;
          count_reg <= count_reg + CW'(1);
          // The result register only moves on the completion edge
          if (last_shift) begin
            bcd_reg  <= work_next;
            done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy = (state_reg == SHIFT);
    bus.done = done_reg;
    bus.bcd  = bcd_reg;
  end
endmodule

// File: tb/tb_calc_bin2bcd.sv
// Randomised self-checking bench for calc_bin2bcd against an arithmetic BCD model.
// Exercises the blank output as well when CALC_BCD_BLANK_EN is defined.
module tb_calc_bin2bcd;
  localparam int N      = 4;
  localparam int DIGITS = 2;
  localparam int MAXV   = (1 << (N + 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [4*DIGITS-1:0] exp_bcd = '0;

  calc_bin2bcd_if #(.N(N), .DIGITS(DIGITS)) bus ();

  calc_bin2bcd #(.N(N), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] ref_blank(input int v);
    logic [DIGITS-1:0] r;
    int p;
    r = '0;
    p = 10;
    for (int i = 1; i < DIGITS; i++) begin
      r[i] = (v < p);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion; at edge-offset 'scramble' the inputs are disturbed and start is pulsed
  task automatic convert(input int v, input int scramble);
    int cyc;
    bus.sum   = v[N-1:0];
    bus.cout  = v[N];
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      check("busy_mid", 32'(bus.busy), 32'd1);
      check("bcd_hold", 32'(bus.bcd), 32'(exp_bcd));
      if (cyc == scramble) begin
        bus.sum   = N'($urandom);
        bus.cout  = 1'($urandom);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    exp_bcd = ref_bcd(v);
    check("latency", 32'(cyc), 32'(N + 1));
    check("bcd", 32'(bus.bcd), 32'(exp_bcd));
    check("busy_at_done", 32'(bus.busy), 32'd0);
`ifdef CALC_BCD_BLANK_EN
    check("blank", 32'(bus.blank), 32'(ref_blank(v)));
`endif
    $display("conv value=%0d bcd=%h cycles=%0d", v, bus.bcd, cyc);
    tick();
    check("done_pulse", 32'(bus.done), 32'd0);
    check("bcd_after", 32'(bus.bcd), 32'(exp_bcd));
  endtask

  initial begin
    int v;
    int ndone;
    bus.start = 1'b0;
    bus.sum   = '0;
    bus.cout  = 1'b0;
    #12;
    check("rst_bcd", 32'(bus.bcd), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
`ifdef CALC_BCD_BLANK_EN
    check("rst_blank", 32'(bus.blank), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();

    convert(3, 99);
    convert(15, 99);
    convert(16, 99);
    convert(30, 99);
    convert(31, 1);
`ifdef CALC_BCD_BLANK_EN
    convert(0, 99);
`endif

    // Start held high: accepts at edge 0 and again the edge after done
    bus.sum = 4'b0000;
    bus.cout = 1'b1;
    bus.start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("b2b_done", 32'(bus.done), 32'((i == N + 1) || (i == 2 * N + 3)));
      if (bus.done) begin
        ndone++;
        check("b2b_bcd", 32'(bus.bcd), 32'h16);
      end
    end
    bus.start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd2);
    $display("b2b value=16 done_pulses=%0d", ndone);
    exp_bcd = ref_bcd(16);
    for (int i = 0; i < N + 3; i++) tick();
    check("b2b_idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of a conversion discards it
    convert(30, 99);
    bus.sum = 4'b0011;
    bus.cout = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("abort_bcd", 32'(bus.bcd), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    tick();
    #3 rst = 1'b0;
    exp_bcd = '0;
    for (int i = 0; i < N + 3; i++) begin
      tick();
      check("abort_nodone", 32'(bus.done), 32'd0);
    end
    $display("abort reset bcd=%h", bus.bcd);
    convert(3, 99);

    for (int t = 0; t < 40; t++) begin
      v = int'($urandom_range(0, MAXV));
      convert(v, int'($urandom_range(0, 2 * N)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
